// File: rtl/turn_controller.sv
// turn_controller: sequences one Othello turn (cursor, occupancy check, detect, flip, swap, redraw)
// against the board store; request lines are registered single windows per visit.
module turn_controller #(
    parameter int DET_CYCLES  = 10,
    parameter int WR_CYCLES   = 10,
    parameter int DRAW_CYCLES = 1280000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic       btn_pass,
    input  logic [1:0] cell_q,
    input  logic [7:0] dir,
    output logic [2:0] cur_x,
    output logic [2:0] cur_y,
    output logic       side,
    output logic       detect_en,
    output logic       write_en,
    output logic       plot_en,
    output logic       busy,
    output logic       illegal,
    output logic       game_over
);
    localparam int M1   = DET_CYCLES > WR_CYCLES ? DET_CYCLES : WR_CYCLES;
    localparam int MAXC = M1 > DRAW_CYCLES ? M1 : DRAW_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, DETECT = 3'd2, EVAL = 3'd3,
                           WRITE = 3'd4, SWAP = 3'd5, DRAW = 3'd6, OVER = 3'd7;
    logic [2:0] state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0] pass_cnt;
    logic [5:0] btn, btn_q, rise;
    logic occupied, no_flip, mv;
    assign btn      = {btn_place, btn_pass, btn_up, btn_down, btn_left, btn_right};
    assign rise     = btn & ~btn_q;
    assign occupied = cell_q >= 2'd2;
    assign no_flip  = dir == 8'd0;
    // cursor moves only when neither place nor pass claimed this cycle's edges
    assign mv       = state == IDLE && !rise[5] && !rise[4];
    assign busy      = state != IDLE && state != OVER;
    assign game_over = state == OVER;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = rise[5] ? CHECK : rise[4] ? SWAP : IDLE;
            CHECK:   state_d = occupied ? IDLE : DETECT;
            DETECT:  state_d = cnt == '0 ? EVAL : DETECT;
            EVAL:    state_d = no_flip ? IDLE : WRITE;
            WRITE:   state_d = cnt == '0 ? SWAP : WRITE;
            SWAP:    state_d = pass_cnt == 2'd2 ? OVER : DRAW;
            DRAW:    state_d = cnt == '0 ? IDLE : DRAW;
            default: state_d = OVER;
        endcase
    end
    always_comb
        cnt_d = state_d == state ? (cnt == '0 ? cnt : cnt - CW'(1)) :
                state_d == DETECT ? CW'(DET_CYCLES - 1) :
                state_d == WRITE ? CW'(WR_CYCLES - 1) : CW'(DRAW_CYCLES - 1);
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= DRAW;
            // one extra count: plot_en rises a cycle after reset releases
            cnt       <= CW'(DRAW_CYCLES);
            btn_q     <= '0;
            cur_x     <= 3'd3;
            cur_y     <= 3'd3;
            side      <= 1'b0;
            pass_cnt  <= 2'd0;
            detect_en <= 1'b0;
            write_en  <= 1'b0;
            plot_en   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            btn_q     <= btn;
            side      <= side ^ (state == SWAP);
            detect_en <= state_d == DETECT;
            write_en  <= state_d == WRITE;
            plot_en   <= state_d == DRAW;
            illegal   <= (state == CHECK && occupied) || (state == EVAL && no_flip);
            if (state == IDLE && !rise[5] && rise[4])
                pass_cnt <= pass_cnt + 2'd1;
            else if (state == EVAL && !no_flip)
                pass_cnt <= 2'd0;
            if (mv && rise[3])
                cur_y <= cur_y - 3'd1;
            else if (mv && rise[2])
                cur_y <= cur_y + 3'd1;
            else if (mv && rise[1])
                cur_x <= cur_x - 3'd1;
            else if (mv && rise[0])
                cur_x <= cur_x + 3'd1;
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: scoreboard bench; stimulus queues expected request windows and illegal
// pulses, a monitor measures each window as it closes and compares against the queue head.
module tb_turn_controller;
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] len;
        logic [2:0] x;
        logic [2:0] y;
        logic       side;
    } ev_t;
    localparam logic [1:0] K_DET = 2'd0, K_WR = 2'd1, K_PLOT = 2'd2, K_ILL = 2'd3;
    localparam logic [5:0] PLACE = 6'b100000, PASS = 6'b010000, UP = 6'b001000,
                           DOWN = 6'b000100, LEFT = 6'b000010, RIGHT = 6'b000001;
    logic clock, resetn;
    logic [5:0] btn;
    logic [1:0] cell_q;
    logic [7:0] dir;
    logic [2:0] cur_x, cur_y;
    logic side, detect_en, write_en, plot_en, busy, illegal, game_over;
    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    int run[4];

    turn_controller #(.DET_CYCLES(10), .WR_CYCLES(10), .DRAW_CYCLES(8)) dut (
        .clock(clock), .resetn(resetn),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .btn_place(btn[5]), .btn_pass(btn[4]),
        .cell_q(cell_q), .dir(dir),
        .cur_x(cur_x), .cur_y(cur_y), .side(side),
        .detect_en(detect_en), .write_en(write_en), .plot_en(plot_en),
        .busy(busy), .illegal(illegal), .game_over(game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        logic [3:0] s;
        ev_t got, want;
        s = {illegal, plot_en, write_en, detect_en};
        for (int k = 0; k < 4; k++) begin
            if (!resetn)
                run[k] = 0;
            else if (s[k])
                run[k]++;
            else if (run[k] > 0) begin
                got.kind = 2'(k);
                got.len  = 8'(run[k]);
                got.x    = cur_x;
                got.y    = cur_y;
                got.side = side;
                run[k]   = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected event: got kind %0d len %0d at (%0d,%0d) side %0d, required none",
                             got.kind, got.len, got.x, got.y, got.side);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL event: got kind %0d len %0d at (%0d,%0d) side %0d, required kind %0d len %0d at (%0d,%0d) side %0d",
                                 got.kind, got.len, got.x, got.y, got.side,
                                 want.kind, want.len, want.x, want.y, want.side);
                    end
                end
            end
        end
    end

    function automatic void expect_ev(input logic [1:0] k, input logic [7:0] l,
                                      input logic [2:0] x, input logic [2:0] y, input logic s);
        exp_q.push_back('{kind: k, len: l, x: x, y: y, side: s});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    task automatic press(input logic [5:0] m);
        @(posedge clock); #1 btn = m;
        @(posedge clock); #1 btn = '0;
    endtask

    task automatic press_n(input logic [5:0] m, input int n);
        for (int i = 0; i < n; i++) press(m);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < limit);
        chk("idle reached", {31'd0, busy}, 0);
    endtask

    initial begin
        resetn = 1'b0;
        btn    = '0;
        cell_q = 2'd0;
        dir    = 8'd0;
        // 1: reset state and initial redraw
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset cur_x", cur_x, 3);
        chk("reset cur_y", cur_y, 3);
        chk("reset side", side, 0);
        chk("reset requests", {detect_en, write_en, plot_en, illegal}, 0);
        chk("reset busy", busy, 1);
        chk("reset game_over", game_over, 0);
        expect_ev(K_PLOT, 8, 3, 3, 0);
        @(posedge clock); #1 resetn = 1'b1;
        wait_idle(50);
        chk("post-draw cur", {cur_x, cur_y}, {3'd3, 3'd3});
        // 2: legal placement at (5,3)
        press_n(RIGHT, 2);
        @(negedge clock);
        chk("cursor right x2", {cur_x, cur_y}, {3'd5, 3'd3});
        dir = 8'h40;
        expect_ev(K_DET, 10, 5, 3, 0);
        expect_ev(K_WR, 10, 5, 3, 0);
        expect_ev(K_PLOT, 8, 5, 3, 1);
        press(PLACE);
        wait_idle(100);
        chk("side after legal place", side, 1);
        // 3: no flips at (0,0)
        press_n(LEFT, 5);
        press_n(UP, 3);
        @(negedge clock);
        chk("cursor to origin", {cur_x, cur_y}, 0);
        dir = 8'h00;
        expect_ev(K_DET, 10, 0, 0, 1);
        expect_ev(K_ILL, 1, 0, 0, 1);
        press(PLACE);
        wait_idle(100);
        chk("side after no-flip", side, 1);
        // 4: occupied cell rejected straight from CHECK
        press_n(RIGHT, 3);
        press_n(DOWN, 3);
        cell_q = 2'd2;
        expect_ev(K_ILL, 1, 3, 3, 1);
        press(PLACE);
        wait_idle(20);
        chk("illegal on CHECK+1", illegal, 1);
        @(negedge clock);
        chk("illegal one cycle", illegal, 0);
        cell_q = 2'd0;
        // 5: wrap-around, held button, simultaneous edges
        press_n(LEFT, 3);
        @(negedge clock);
        chk("x at 0", cur_x, 0);
        press(LEFT);
        @(negedge clock);
        chk("x wraps to 7", cur_x, 7);
        press_n(UP, 3);
        press(UP);
        @(negedge clock);
        chk("y wraps to 7", cur_y, 7);
        @(posedge clock); #1 btn = UP;
        repeat (20) @(posedge clock);
        #1 btn = '0;
        @(negedge clock);
        chk("held up moves once", cur_y, 6);
        press(UP | LEFT);
        @(negedge clock);
        chk("up beats left", {cur_x, cur_y}, {3'd7, 3'd5});
        press(RIGHT);
        @(negedge clock);
        chk("x wraps to 0", cur_x, 0);
        // 6: two passes end the game
        expect_ev(K_PLOT, 8, 0, 5, 0);
        press(PASS);
        wait_idle(50);
        press(PASS);
        wait_idle(50);
        chk("side after two passes", side, 1);
        chk("game_over set", game_over, 1);
        press(PLACE);
        press(RIGHT);
        press(PASS);
        repeat (5) @(negedge clock);
        chk("cursor frozen in OVER", {cur_x, cur_y}, {3'd0, 3'd5});
        chk("game_over sticky", game_over, 1);
        chk("no request in OVER", {detect_en, write_en, plot_en}, 0);
        @(posedge clock); #1 resetn = 1'b0;
        repeat (3) @(posedge clock);
        expect_ev(K_PLOT, 8, 3, 3, 0);
        #1 resetn = 1'b1;
        wait_idle(50);
        chk("game_over cleared", game_over, 0);
        // pass, legal place, pass: the place resets the pass count
        expect_ev(K_PLOT, 8, 3, 3, 1);
        press(PASS);
        wait_idle(50);
        dir = 8'h01;
        expect_ev(K_DET, 10, 3, 3, 1);
        expect_ev(K_WR, 10, 3, 3, 1);
        expect_ev(K_PLOT, 8, 3, 3, 0);
        press(PLACE);
        wait_idle(100);
        expect_ev(K_PLOT, 8, 3, 3, 1);
        press(PASS);
        wait_idle(50);
        chk("no game_over after place", game_over, 0);
        chk("side after pass/place/pass", side, 1);
        // abort mid-WRITE
        expect_ev(K_DET, 10, 3, 3, 1);
        press(PLACE);
        begin
            int n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!write_en && n < 100);
            chk("write_en reached", write_en, 1);
        end
        repeat (3) @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock); #1;
        chk("write_en drops on reset", write_en, 0);
        chk("side reset", side, 0);
        chk("busy in reset", busy, 1);
        repeat (2) @(posedge clock);
        expect_ev(K_PLOT, 8, 3, 3, 0);
        #1 resetn = 1'b1;
        wait_idle(50);
        repeat (5) @(negedge clock);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
